// File: rtl/dice_game_ctrl.sv
// dice_game_ctrl: dice-guessing game with debounced buttons, LFSR die, saturating score and 4-digit 7-segment scan
// Ports:
//   rclock     system clock
//   rst        synchronous reset, active-high
//   button     raw buttons: [0] roll, [1] guess step, [2] clear, [3] reserved (ignored)
//   guess      current guess, 1..FACES
//   roll       last die value, 0 = none yet
//   point      score, binary
//   game_over  high while the game is over
//   out        segments {a,b,c,d,e,f,g,dp}, active-low
//   an         digit anodes, active-low
// Optional: define STREAK_BONUS_EN to add a hit-streak counter that doubles the bonus on repeated hits
module dice_game_ctrl #(
    parameter int                FACES        = 6,
    parameter int                LFSR_W       = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8,
    parameter int                START_SCORE  = 10,
    parameter int                SCORE_MAX    = 99,
    parameter int                WIN_BONUS    = 6,
    parameter int                LOSS_PENALTY = 1,
    parameter int                DEB_CYCLES   = 16,
    parameter int                SCAN_LOG2    = 15
) (
    input  logic       rclock,
    input  logic       rst,
    input  logic [3:0] button,
    output logic [3:0] guess,
    output logic [3:0] roll,
    output logic [6:0] point,
    output logic       game_over,
    output logic [7:0] out,
    output logic [3:0] an
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int SW = SCAN_LOG2 + 2;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    state_t state, state_n;

    logic [2:0]    s1, s2, lvl, lvl_d, press;
    logic [CW-1:0] cnt [3];
    logic          unused_btn;
    assign unused_btn = button[3];

    // sync -> debounce -> rising-edge pulse, one lane per used button
    always_ff @(posedge rclock) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1    <= button[2:0];
            s2    <= s1;
            lvl_d <= lvl;
            press <= lvl & ~lvl_d;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == lvl[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    lvl[i] <= s2[i];
                end else cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    logic [LFSR_W-1:0] lfsr;
    always_ff @(posedge rclock) begin
        if (rst) lfsr <= LFSR_W'(1);
        else lfsr <= (lfsr == '0) ? LFSR_W'(1) : {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end

    logic [3:0] die, guess_n, roll_n;
    logic [6:0] point_n, new_pt;
    logic [7:0] bonus, up;
    logic       hit, do_roll, dp1;
    assign die = 4'(lfsr % LFSR_W'(FACES)) + 4'd1;
`ifdef STREAK_BONUS_EN
    logic [2:0] streak, streak_n;
    assign bonus = (streak == 3'd0) ? 8'(WIN_BONUS) : 8'(2 * WIN_BONUS);
    assign dp1   = streak >= 3'd2;
    always_ff @(posedge rclock) begin
        if (rst) streak <= 3'd0;
        else streak <= streak_n;
    end
`else
    assign bonus = 8'(WIN_BONUS);
    assign dp1   = 1'b0;
`endif
    assign hit     = die == guess;
    assign up      = 8'(point) + bonus;
    assign new_pt  = hit ? ((up > 8'(SCORE_MAX)) ? 7'(SCORE_MAX) : up[6:0])
                         : ((point >= 7'(LOSS_PENALTY)) ? point - 7'(LOSS_PENALTY) : 7'd0);
    assign do_roll = press[0] && state != OVER;

    // clear wins over everything; a same-cycle guess step uses the pre-increment guess for scoring
    always_comb begin
        state_n = state;
        guess_n = guess;
        roll_n  = roll;
        point_n = point;
`ifdef STREAK_BONUS_EN
        streak_n = streak;
`endif
        if (press[2]) begin
            state_n = IDLE;
            guess_n = 4'd1;
            roll_n  = 4'd0;
            point_n = 7'(START_SCORE);
`ifdef STREAK_BONUS_EN
            streak_n = 3'd0;
`endif
        end else begin
            if (do_roll) begin
                roll_n  = die;
                point_n = new_pt;
                state_n = (state == PLAY && new_pt == 7'd0) ? OVER : PLAY;
`ifdef STREAK_BONUS_EN
                streak_n = hit ? ((streak == 3'd7) ? streak : streak + 3'd1) : 3'd0;
`endif
            end
            if (press[1] && state != OVER) guess_n = (guess == 4'(FACES)) ? 4'd1 : guess + 4'd1;
        end
    end

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 8'h03;
            4'd1: seg = 8'h9F;
            4'd2: seg = 8'h25;
            4'd3: seg = 8'h0D;
            4'd4: seg = 8'h99;
            4'd5: seg = 8'h49;
            4'd6: seg = 8'h41;
            4'd7: seg = 8'h1F;
            4'd8: seg = 8'h01;
            4'd9: seg = 8'h09;
            default: seg = 8'hFF;
        endcase
    endfunction

    logic [SW-1:0] scan;
    logic [1:0]    sel;
    logic [3:0]    tens, units;
    logic [7:0]    out_n;
    assign sel   = scan[SW-1 -: 2];
    assign tens  = 4'(point / 7'd10);
    assign units = 4'(point % 7'd10);
    assign out_n = (sel == 2'd0) ? ((state == OVER || roll == 4'd0) ? 8'hFD : seg(roll)) :
                   (sel == 2'd1) ? (((state == OVER) ? 8'hFD : seg(guess)) & {7'h7F, ~dp1}) :
                   (sel == 2'd2) ? seg(units) :
                                   (seg(tens) & {7'h7F, state != OVER});
    assign game_over = state == OVER;

    always_ff @(posedge rclock) begin
        if (rst) begin
            state <= IDLE;
            guess <= 4'd1;
            roll  <= 4'd0;
            point <= 7'(START_SCORE);
            scan  <= '0;
            an    <= 4'hF;
            out   <= 8'hFF;
        end else begin
            state <= state_n;
            guess <= guess_n;
            roll  <= roll_n;
            point <= point_n;
            scan  <= scan + SW'(1);
            an    <= ~(4'b0001 << sel);
            out   <= out_n;
        end
    end
endmodule
